dmux_serializer: RTL and testbench

Upstream feeder for the registered 1-to-4 bit demultiplexer. Accepts a parallel word plus a 2-bit destination channel over a valid/ready handshake. Shifts the word out MSB-first, one bit per clock, on `out_bit` while holding `out_sel` stable. These drive the demux's `in` and `sel` directly. Inserts a programmable idle gap between words so each channel sees clean, zero-separated frames.

---
 rtl/dmux_pkg.sv | 16 +
 rtl/dmux_down_cnt.sv | 28 ++
 rtl/dmux_serializer.sv | 104 ++++++++++
 tb/tb_dmux_serializer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared types and constants for the demux serializer slice.
// Channel constants map a destination code onto demux outputs a..d.
package dmux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/dmux_down_cnt.sv
// Loadable down-counter with a zero flag.
// Decrementing saturates at zero, so a stray decrement never wraps.
module dmux_down_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/dmux_serializer.sv
// Serializes a parallel word MSB-first toward a 1-to-4 demux, holding the
// channel select steady per frame and inserting an idle gap between words.
module dmux_serializer
    import dmux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic [1:0]       s_dest,
    output logic             out_bit,
    output logic [1:0]       out_sel,
    output logic             out_active,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t           state_q;
    logic [WIDTH-2:0] shift_q;
    logic             outBit_q;
    logic [1:0]       outSel_q;
    logic             outActive_q;

    logic accept;
    logic bitZero;
    logic gapZero;
    logic gapLoad;

    assign s_ready    = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign accept     = s_valid && s_ready;
    assign gapLoad    = (GAP > 0) && (state_q == ST_SHIFT) && bitZero;
    assign out_bit    = outBit_q;
    assign out_sel    = outSel_q;
    assign out_active = outActive_q;

    dmux_down_cnt #(.W(CW)) u_bit_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (BIT_LOAD),
        .dec_i      ((state_q == ST_SHIFT) && !bitZero),
        .zero_o     (bitZero)
    );

    dmux_down_cnt #(.W(4)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gapLoad),
        .load_val_i (GAP_LOAD),
        .dec_i      ((state_q == ST_GAP) && !gapZero),
        .zero_o     (gapZero)
    );

    // The MSB goes straight to out_bit on accept, so the shift register only
    // needs to hold the remaining WIDTH-1 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            outBit_q    <= 1'b0;
            outSel_q    <= CH_A;
            outActive_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q     <= s_data[WIDTH-2:0];
                        outSel_q    <= s_dest;
                        outBit_q    <= s_data[WIDTH-1];
                        outActive_q <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!bitZero) begin
                        outBit_q <= shift_q[WIDTH-2];
                        shift_q  <= shift_q << 1;
                    end else begin
                        outBit_q    <= 1'b0;
                        outActive_q <= 1'b0;
                        state_q     <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gapZero) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmux_serializer.sv
// Directed bench for dmux_serializer: a GAP=1 instance plus a GAP=0 instance,
// with a registered 1-to-4 demux model on the GAP=1 output for end-to-end checks.
module tb_dmux_serializer;

    logic       clk;
    logic       rst_n;

    logic       sValid;
    logic       sReady;
    logic [7:0] sData;
    logic [1:0] sDest;
    logic       outBit;
    logic [1:0] outSel;
    logic       outActive;
    logic       busy;

    logic       sValid0;
    logic       sReady0;
    logic [7:0] sData0;
    logic [1:0] sDest0;
    logic       outBit0;
    logic [1:0] outSel0;
    logic       outActive0;
    logic       busy0;

    logic dmA, dmB, dmC, dmD;

    int errors = 0;
    int checks = 0;

    dmux_serializer #(.WIDTH(8), .GAP(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (sValid),
        .s_ready    (sReady),
        .s_data     (sData),
        .s_dest     (sDest),
        .out_bit    (outBit),
        .out_sel    (outSel),
        .out_active (outActive),
        .busy       (busy)
    );

    dmux_serializer #(.WIDTH(8), .GAP(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (sValid0),
        .s_ready    (sReady0),
        .s_data     (sData0),
        .s_dest     (sDest0),
        .out_bit    (outBit0),
        .out_sel    (outSel0),
        .out_active (outActive0),
        .busy       (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference registered demux: selected output follows in one cycle later,
    // all others are forced to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {dmA, dmB, dmC, dmD} <= 4'b0000;
        end else begin
            dmA <= (outSel == 2'd0) ? outBit : 1'b0;
            dmB <= (outSel == 2'd1) ? outBit : 1'b0;
            dmC <= (outSel == 2'd2) ? outBit : 1'b0;
            dmD <= (outSel == 2'd3) ? outBit : 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] dst);
        sValid = v;
        sData  = d;
        sDest  = dst;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] word;
        logic [7:0] word2;

        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 2'd0);
        sValid0 = 1'b0;
        sData0  = 8'h00;
        sDest0  = 2'd0;

        // Reset state
        #3;
        checkOutput("rst_out_bit", outBit, 0);
        checkOutput("rst_out_active", outActive, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_sel", outSel, 0);
        checkOutput("rst_s_ready", sReady, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Single word 0xA5 to channel 2
        $display("[TB] single word");
        word = 8'hA5;
        applyStimulus(1'b1, word, 2'd2);
        step();
        applyStimulus(1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("single_bit", outBit, word[7-k]);
            checkOutput("single_active", outActive, 1);
            checkOutput("single_sel", outSel, 2);
            checkOutput("single_ready_low", sReady, 0);
            step();
        end
        checkOutput("single_gap_bit", outBit, 0);
        checkOutput("single_gap_active", outActive, 0);
        checkOutput("single_gap_busy", busy, 1);
        checkOutput("single_gap_ready", sReady, 0);
        step();
        checkOutput("single_ready_back", sReady, 1);
        checkOutput("single_idle_busy", busy, 0);
        checkOutput("single_idle_sel", outSel, 2);

        // Back-to-back words with s_valid held
        $display("[TB] back-to-back");
        word  = 8'hFF;
        word2 = 8'h01;
        applyStimulus(1'b1, word, 2'd0);
        step();
        applyStimulus(1'b1, word2, 2'd3);
        for (int k = 0; k < 9; k++) begin
            if (k < 8) checkOutput("b2b_first_bit", outBit, word[7-k]);
            checkOutput("b2b_sel_hold", outSel, 0);
            step();
        end
        checkOutput("b2b_ready_at_9", sReady, 1);
        checkOutput("b2b_sel_before", outSel, 0);
        step();
        checkOutput("b2b_sel_after", outSel, 3);
        checkOutput("b2b_active_at_10", outActive, 1);
        checkOutput("b2b_second_bit", outBit, word2[7]);
        applyStimulus(1'b0, 8'h00, 2'd0);
        for (int k = 1; k < 8; k++) begin
            step();
            checkOutput("b2b_second_bit", outBit, word2[7-k]);
        end
        step();
        step();

        // Inputs change while shifting; latched word must win
        $display("[TB] backpressure");
        word = 8'h96;
        applyStimulus(1'b1, word, 2'd0);
        step();
        applyStimulus(1'b1, 8'h00, 2'd1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("bp_bit", outBit, word[7-k]);
            checkOutput("bp_sel", outSel, 0);
            step();
        end
        applyStimulus(1'b0, 8'h00, 2'd0);
        checkOutput("bp_ready_gap", sReady, 0);
        step();
        checkOutput("bp_ready_back", sReady, 1);
        step();
        checkOutput("bp_no_accept", busy, 0);
        checkOutput("bp_sel_final", outSel, 0);

        // Reset mid-word after bit 3
        $display("[TB] reset mid-word");
        word = 8'hF0;
        applyStimulus(1'b1, word, 2'd2);
        step();
        applyStimulus(1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("mid_bit", outBit, word[7-k]);
            if (k < 3) step();
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_bit", outBit, 0);
        checkOutput("mid_rst_active", outActive, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_sel", outSel, 0);
        checkOutput("mid_rst_ready", sReady, 1);
        #2 rst_n = 1'b1;
        step();
        checkOutput("post_rst_ready", sReady, 1);
        word = 8'h5A;
        applyStimulus(1'b1, word, 2'd1);
        step();
        applyStimulus(1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("post_rst_bit", outBit, word[7-k]);
            checkOutput("post_rst_sel", outSel, 1);
            step();
        end
        step();

        // GAP=0 instance, two queued words
        $display("[TB] gap zero");
        word  = 8'h80;
        word2 = 8'h01;
        sValid0 = 1'b1;
        sData0  = word;
        sDest0  = 2'd1;
        step();
        sData0 = word2;
        sDest0 = 2'd2;
        for (int k = 0; k < 8; k++) begin
            checkOutput("g0_bit", outBit0, word[7-k]);
            checkOutput("g0_active", outActive0, 1);
            step();
        end
        checkOutput("g0_active_low", outActive0, 0);
        checkOutput("g0_ready", sReady0, 1);
        checkOutput("g0_sel_hold", outSel0, 1);
        step();
        sValid0 = 1'b0;
        checkOutput("g0_active_again", outActive0, 1);
        checkOutput("g0_sel_new", outSel0, 2);
        checkOutput("g0_second_bit", outBit0, word2[7]);
        for (int k = 1; k < 8; k++) begin
            step();
            checkOutput("g0_second_bit", outBit0, word2[7-k]);
        end
        step();
        checkOutput("g0_idle_ready", sReady0, 1);

        // End-to-end through the demux model
        $display("[TB] end-to-end");
        word = 8'h81;
        applyStimulus(1'b1, word, 2'd1);
        step();
        applyStimulus(1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            checkOutput("e2e_b", dmB, word[7-k]);
            checkOutput("e2e_acd", {dmA, dmC, dmD}, 0);
        end
        step();
        checkOutput("e2e_b_idle", dmB, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
